mux_scan_sampler: RTL and testbench
===================================

Name: mux_scan_sampler

Overview:
Parametrised N_CH:1 multiplexer with a registered output and a built-in channel sequencer. It operates in two modes. In manual mode it registers the channel picked by `sel` every cycle. In scan mode a single `start` pulse makes it step through every channel in order, holding each for a programmable dwell time, and it reports channel number, valid and done. It is the sequential successor to the combinational 16:1 mux and is used wherever a bank of status/data lines must be polled in turn.

Parameters:
N_CH, 16, number of input channels (>=2; need not be a power of two)
WIDTH, 8, bits per channel
DWELL, 1, cycles spent on each channel in scan mode (>=1)
SW, $clog2(N_CH), select/channel-index width (derived, not overridden)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  synchronous, active-high reset
in_data  in  N_CH*WIDTH  packed channels; channel i = in_data[i*WIDTH +: WIDTH]
mode  in  1  0 = manual, 1 = scan; sampled only in IDLE
sel  in  SW  manual-mode channel select
start  in  1  scan request pulse; acted on only in IDLE with mode=1
abort  in  1  terminates an active scan
out_data  out  WIDTH  registered selected channel data
out_ch  out  SW  channel index corresponding to out_data
out_valid  out  1  out_data/out_ch updated this cycle
busy  out  1  scan in progress
done  out  1  one-cycle pulse on scan completion

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state changes occur on the rising edge of `clk`.
- Reset (rst=1 at an edge): state=IDLE, ch=0, dwell_cnt=0. out_data=0, out_ch=0, out_valid=0, busy=0, done=0. Reset overrides all other inputs, including mid-scan: no done pulse is produced.
- States: IDLE and SCAN. busy = (state==SCAN), driven from the registered state.
- IDLE, mode=0 (manual):
  - Each edge loads out_data<=channel[sel], out_ch<=sel and out_valid<=1.
  - Latency is 1 cycle: a change on sel in cycle k is visible in cycle k+1.
  - If sel>=N_CH (non-power-of-two N_CH), out_data<=0 and out_ch<=sel, with out_valid still 1.
  - start is ignored.
- IDLE, mode=1, start=0: out_valid<=0, and out_data/out_ch hold their last values.
- IDLE, mode=1, start=1: transition to SCAN with ch<=0 and dwell_cnt<=0. out_valid<=0.
- SCAN, each edge:
  - If abort=1: go to IDLE, out_valid<=0, done<=0. Abort takes priority over sampling in the same cycle.
  - Else if dwell_cnt==DWELL-1: out_data<=channel[ch], out_ch<=ch, out_valid<=1, dwell_cnt<=0. If ch==N_CH-1, go to IDLE and set done<=1; otherwise ch<=ch+1.
  - Else: dwell_cnt<=dwell_cnt+1 and out_valid<=0.
- Scan timing when start is sampled high in cycle k:
  - busy is high in cycles k+1 .. k+N_CH*DWELL.
  - Channel c is valid in cycle k+1+(c+1)*DWELL.
  - done and the last out_valid are both high in cycle k+1+N_CH*DWELL, the first cycle in which busy=0.
- In SCAN, mode, sel and start are ignored. A start arriving while busy is dropped, not queued.
- done is high for exactly one cycle per completed scan and is otherwise 0.
- Data is sampled from in_data at the sampling edge. in_data does not need to be stable for the whole dwell time.
- Back-to-back scans: if start=1 and mode=1 in the done cycle (state already IDLE), a new scan starts. There are no idle gaps beyond that cycle.
- dwell_cnt width is $clog2(DWELL) with a minimum of 1. When DWELL=1 the counter is always 0 and every SCAN cycle samples.
- The channel index never wraps inside a scan. It always ends at N_CH-1 unless the scan is aborted or reset.

Test Plan:
1. Manual sweep: N_CH=16, WIDTH=8, channel i=8'hA0+i, mode=0. Step sel 0..15 one value per cycle → one cycle later out_data=A0+sel, out_ch=sel, out_valid=1 on every cycle.
2. Full scan, DWELL=1: mode=1, start pulsed in cycle k → busy high in k+1..k+16; out_valid high in k+2..k+17 with out_data A0..AF in order; done=1 only in cycle k+17.
3. Dwell: DWELL=3, N_CH=4 → out_valid high only in cycles k+4, k+7, k+10, k+13 with out_ch=0..3; done in k+13; busy high in k+1..k+12.
4. Abort and ignored start: during a DWELL=1 scan, pulse start at ch=5 (no effect), then abort at ch=8 → next cycle busy=0, no done; the last valid out_ch is 7 and out_data holds A7.
5. Reset mid-scan: assert rst at ch=10 → next cycle all outputs are 0 and the state is IDLE; a following start produces a full scan beginning at channel 0.
6. Non-power-of-two: N_CH=5 manual mode with sel=6 → out_data=0, out_valid=1; scan mode covers channels 0..4 and done follows channel 4.

Source files
------------

// File: rtl/mux_scan_sampler.sv
// rtl/mux_scan_sampler.sv - N_CH:1 registered mux with manual select and timed channel scan
// Manual mode follows sel each cycle; scan mode walks every channel once per start pulse.
module mux_scan_sampler #(
  parameter int N_CH  = 16,
  parameter int WIDTH = 8,
  parameter int DWELL = 1,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic                    mode,
  input  logic [SW-1:0]           sel,
  input  logic                    start,
  input  logic                    abort,
  output logic [WIDTH-1:0]        out_data,
  output logic [SW-1:0]           out_ch,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t         state, state_n;
  logic [SW-1:0]  ch, ch_n;
  logic [DW-1:0]  dwell_cnt, dwell_n;

  logic [WIDTH-1:0] data_n;
  logic [SW-1:0]    och_n;
  logic             valid_n;
  logic             done_n;

  logic last_dwell;
  logic last_ch;

  // Indices beyond N_CH-1 (non-power-of-two banks) read as zero.
  function automatic logic [WIDTH-1:0] pick(input logic [SW-1:0]         idx,
                                            input logic [N_CH*WIDTH-1:0] bus);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx == SW'(i)) begin
        r = bus[i*WIDTH +: WIDTH];
      end
    end
    return r;
  endfunction

  assign last_dwell = (dwell_cnt == DW'(DWELL - 1));
  assign last_ch    = (ch == SW'(N_CH - 1));
  assign busy       = (state == SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      dwell_cnt <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      ch        <= ch_n;
      dwell_cnt <= dwell_n;
      out_data  <= data_n;
      out_ch    <= och_n;
      out_valid <= valid_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    ch_n    = ch;
    dwell_n = dwell_cnt;
    case (state)
      IDLE: begin
        if (mode && start) begin
          state_n = SCAN;
          ch_n    = '0;
          dwell_n = '0;
        end
      end
      SCAN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (last_dwell) begin
          dwell_n = '0;
          if (last_ch) begin
            state_n = IDLE;
          end else begin
            ch_n = ch + SW'(1);
          end
        end else begin
          dwell_n = dwell_cnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Data/channel hold their last value whenever nothing is sampled.
  always_comb begin
    data_n  = out_data;
    och_n   = out_ch;
    valid_n = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!mode) begin
          data_n  = pick(sel, in_data);
          och_n   = sel;
          valid_n = 1'b1;
        end
      end
      SCAN: begin
        if (!abort && last_dwell) begin
          data_n  = pick(ch, in_data);
          och_n   = ch;
          valid_n = 1'b1;
          done_n  = last_ch;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb/tb_mux_scan_sampler.sv - directed bench for mux_scan_sampler
// Three instances: 16ch/dwell 1, 4ch/dwell 3, 5ch/dwell 1.
module tb_mux_scan_sampler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [16*8-1:0] a_in;
  logic            a_mode, a_start, a_abort;
  logic [3:0]      a_sel;
  logic [7:0]      a_data;
  logic [3:0]      a_ch;
  logic            a_valid, a_busy, a_done;

  logic [4*8-1:0]  b_in;
  logic            b_mode, b_start, b_abort;
  logic [1:0]      b_sel;
  logic [7:0]      b_data;
  logic [1:0]      b_ch;
  logic            b_valid, b_busy, b_done;

  logic [5*8-1:0]  c_in;
  logic            c_mode, c_start, c_abort;
  logic [2:0]      c_sel;
  logic [7:0]      c_data;
  logic [2:0]      c_ch;
  logic            c_valid, c_busy, c_done;

  mux_scan_sampler #(.N_CH(16), .WIDTH(8), .DWELL(1)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in), .mode(a_mode), .sel(a_sel),
    .start(a_start), .abort(a_abort), .out_data(a_data), .out_ch(a_ch),
    .out_valid(a_valid), .busy(a_busy), .done(a_done)
  );

  mux_scan_sampler #(.N_CH(4), .WIDTH(8), .DWELL(3)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in), .mode(b_mode), .sel(b_sel),
    .start(b_start), .abort(b_abort), .out_data(b_data), .out_ch(b_ch),
    .out_valid(b_valid), .busy(b_busy), .done(b_done)
  );

  mux_scan_sampler #(.N_CH(5), .WIDTH(8), .DWELL(1)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in), .mode(c_mode), .sel(c_sel),
    .start(c_start), .abort(c_abort), .out_data(c_data), .out_ch(c_ch),
    .out_valid(c_valid), .busy(c_busy), .done(c_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse in cycle k, then check cycles k+1 .. k+18.
  task automatic full_scan_a(input string tag);
    a_mode  = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      check({tag, "_busy"},  32'(a_busy),  32'(n >= 1 && n <= 16));
      check({tag, "_valid"}, 32'(a_valid), 32'(n >= 2 && n <= 17));
      check({tag, "_done"},  32'(a_done),  32'(n == 17));
      if (n >= 2 && n <= 17) begin
        check({tag, "_ch"},   32'(a_ch),   32'(n - 2));
        check({tag, "_data"}, 32'(a_data), 32'(8'hA0 + n - 2));
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) a_in[i*8 +: 8] = 8'(8'hA0 + i);
    for (int i = 0; i < 4; i++)  b_in[i*8 +: 8] = 8'(8'hA0 + i);
    for (int i = 0; i < 5; i++)  c_in[i*8 +: 8] = 8'(8'hA0 + i);
    {a_mode, a_start, a_abort, a_sel} = '0;
    {b_mode, b_start, b_abort, b_sel} = '0;
    {c_mode, c_start, c_abort, c_sel} = '0;
    a_sel = 4'd3;
    rst = 1'b1;
    tick();
    tick();

    check("rst_data",  32'(a_data),  32'h0);
    check("rst_ch",    32'(a_ch),    32'h0);
    check("rst_valid", 32'(a_valid), 32'h0);
    check("rst_busy",  32'(a_busy),  32'h0);
    check("rst_done",  32'(a_done),  32'h0);
    rst = 1'b0;

    // Manual sweep, one cycle latency.
    for (int s = 0; s < 16; s++) begin
      a_sel = 4'(s);
      tick();
      check("man_data",  32'(a_data),  32'(8'hA0 + s));
      check("man_ch",    32'(a_ch),    32'(s));
      check("man_valid", 32'(a_valid), 32'h1);
    end

    full_scan_a("scan1");

    // Dwell 3 on the 4-channel instance.
    b_mode  = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      check("dw_busy",  32'(b_busy),  32'(n >= 1 && n <= 12));
      check("dw_valid", 32'(b_valid), 32'(n == 4 || n == 7 || n == 10 || n == 13));
      check("dw_done",  32'(b_done),  32'(n == 13));
      if (n == 4 || n == 7 || n == 10 || n == 13) begin
        check("dw_ch",   32'(b_ch),   32'((n - 4) / 3));
        check("dw_data", 32'(b_data), 32'(8'hA0 + (n - 4) / 3));
      end
      tick();
    end

    // Ignored start at ch=5, abort at ch=8.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      check("ab_busy", 32'(a_busy), 32'h1);
      check("ab_done", 32'(a_done), 32'h0);
      a_start = (n == 6);
      a_abort = (n == 9);
      tick();
    end
    a_start = 1'b0;
    a_abort = 1'b0;
    check("ab_after_busy",  32'(a_busy),  32'h0);
    check("ab_after_done",  32'(a_done),  32'h0);
    check("ab_after_valid", 32'(a_valid), 32'h0);
    check("ab_after_ch",    32'(a_ch),    32'h7);
    check("ab_after_data",  32'(a_data),  32'hA7);
    tick();
    check("ab_later_done",  32'(a_done),  32'h0);
    check("ab_later_busy",  32'(a_busy),  32'h0);

    // Reset while the scan sits on ch=10 (cycle k+11).
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int n = 1; n <= 10; n++) tick();
    check("mid_busy", 32'(a_busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_data",  32'(a_data),  32'h0);
    check("mrst_ch",    32'(a_ch),    32'h0);
    check("mrst_valid", 32'(a_valid), 32'h0);
    check("mrst_busy",  32'(a_busy),  32'h0);
    check("mrst_done",  32'(a_done),  32'h0);
    tick();
    check("mrst_idle_busy", 32'(a_busy), 32'h0);
    check("mrst_idle_done", 32'(a_done), 32'h0);
    full_scan_a("scan2");

    // Non-power-of-two channel count.
    c_mode = 1'b0;
    c_sel  = 3'd6;
    tick();
    check("np2_oob_data",  32'(c_data),  32'h0);
    check("np2_oob_ch",    32'(c_ch),    32'h6);
    check("np2_oob_valid", 32'(c_valid), 32'h1);
    c_sel = 3'd4;
    tick();
    check("np2_sel4_data", 32'(c_data), 32'hA4);
    c_mode  = 1'b1;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      check("np2_busy",  32'(c_busy),  32'(n >= 1 && n <= 5));
      check("np2_valid", 32'(c_valid), 32'(n >= 2 && n <= 6));
      check("np2_done",  32'(c_done),  32'(n == 6));
      if (n >= 2 && n <= 6) begin
        check("np2_ch",   32'(c_ch),   32'(n - 2));
        check("np2_data", 32'(c_data), 32'(8'hA0 + n - 2));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
